// File: rtl/bus_ram_target.sv
// Word-addressed RAM bus target with programmable wait states and abortable requests.
// Optional range checking with o_bus_error is enabled by defining BUS_RAM_TARGET_ERR_EN.
module bus_ram_target #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_bus_request,
   input  logic        i_bus_rw,
   input  logic [31:0] i_bus_address,
   input  logic [31:0] i_bus_wdata,
   output logic [31:0] o_bus_rdata,
   output logic        o_bus_ready
`ifdef BUS_RAM_TARGET_ERR_EN
   ,
   output logic        o_bus_error
`endif
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

   state_t          state, state_nx;
   logic [3:0]      cnt, cnt_nx;
   logic            ready_q;
   logic            rw_q;
   logic [AW-1:0]   idx_q;
   logic [31:0]     wdata_q;
   logic            err_q;
   logic            accept;
   logic            range_err;
   logic [31:0]     mem [DEPTH];

   // Byte-lane bits (and, without range checking, the upper bits) never select a word.
   logic unused_addr;
   assign unused_addr = ^i_bus_address;

`ifdef BUS_RAM_TARGET_ERR_EN
   assign range_err = |i_bus_address[31:AW+2];
`else
   assign range_err = 1'b0;
`endif

   assign accept = (state == IDLE) && i_bus_request;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (i_bus_request) begin
               cnt_nx   = 4'(WAIT_STATES);
               state_nx = (WAIT_STATES > 0) ? WAIT : RESPOND;
            end
         end
         WAIT: begin
            if (!i_bus_request) begin
               // Initiator gave up: abandon without a response or write.
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt - 4'd1;
               if (cnt <= 4'd1) state_nx = RESPOND;
            end
         end
         RESPOND: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state   <= IDLE;
         cnt     <= '0;
         ready_q <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         ready_q <= (state_nx == RESPOND);
      end
   end

   always_ff @(posedge i_clock) begin
      if (accept && !i_reset) begin
         rw_q    <= i_bus_rw;
         idx_q   <= i_bus_address[AW+1:2];
         wdata_q <= i_bus_wdata;
         err_q   <= range_err;
      end
   end

   // Memory is never cleared; a write commits on the edge that ends RESPOND.
   always_ff @(posedge i_clock) begin
      if (!i_reset && state == RESPOND && rw_q && !err_q)
         mem[idx_q] <= wdata_q;
   end

   assign o_bus_ready = ready_q;
   assign o_bus_rdata = (ready_q && !rw_q && !err_q) ? mem[idx_q] : '0;
`ifdef BUS_RAM_TARGET_ERR_EN
   assign o_bus_error = ready_q & err_q;
`endif

endmodule
